// File: rtl/dma_pkg.sv
// Shared types and constants for the memory DMA initiator.
// Provides the FSM state enum, transfer mode codes and memory depth.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ,
    WRITE,
    DONE
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam int DEPTH = 256;

endpackage

// File: rtl/mem_dma_initiator.sv
// Bus master for the data memory port: block copy or pattern fill.
// Ports: CLK/RST, start/mode/src/dst/len/pattern request, busy/done/err
// status, mem_a/mem_wd/mem_we/mem_rd memory master port.
module mem_dma_initiator #(
  parameter int WL    = 32,
  parameter int DEPTH = dma_pkg::DEPTH,
  parameter int LENW  = 9
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic            mode,
  input  logic [WL-1:0]   src,
  input  logic [WL-1:0]   dst,
  input  logic [LENW-1:0] len,
  input  logic [WL-1:0]   pattern,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [WL-1:0]   mem_a,
  output logic [WL-1:0]   mem_wd,
  output logic            mem_we,
  input  logic [WL-1:0]   mem_rd
);

  import dma_pkg::*;

  state_e          state_q, state_d;
  logic [WL-1:0]   src_q, src_d;
  logic [WL-1:0]   dst_q, dst_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic [WL-1:0]   pat_q, pat_d;
  logic [WL-1:0]   buf_q, buf_d;
  logic            err_q, err_d;
  logic            we_int;

  // One extra bit so end addresses never wrap.
  logic [WL:0] lim;
  logic [WL:0] src_end;
  logic [WL:0] dst_end;
  logic        range_bad;

  assign lim     = (WL+1)'(DEPTH);
  assign src_end = {1'b0, src_q} + (WL+1)'(cnt_q);
  assign dst_end = {1'b0, dst_q} + (WL+1)'(cnt_q);

  assign range_bad = (dst_end > lim) ||
                     ((mode_q == MODE_COPY) && (src_end > lim));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      pat_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    buf_d   = buf_q;
    err_d   = err_q;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    we_int  = 1'b0;
    mem_a   = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src;
          dst_d   = dst;
          cnt_d   = len;
          mode_d  = mode;
          pat_d   = pattern;
          state_d = CHECK;
        end
      end

      CHECK: begin
        busy  = 1'b1;
        err_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else if (range_bad) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (mode_q == MODE_COPY) begin
          state_d = READ;
        end else begin
          // Fill data lives in the same register that drives mem_wd.
          buf_d   = pat_q;
          state_d = WRITE;
        end
      end

      READ: begin
        busy    = 1'b1;
        mem_a   = src_q;
        buf_d   = mem_rd;
        state_d = WRITE;
      end

      WRITE: begin
        busy   = 1'b1;
        mem_a  = dst_q;
        we_int = 1'b1;
        src_d  = src_q + WL'(1);
        dst_d  = dst_q + WL'(1);
        cnt_d  = cnt_q - LENW'(1);
        if (cnt_q == LENW'(1)) begin
          state_d = DONE;
        end else if (mode_q == MODE_COPY) begin
          state_d = READ;
        end else begin
          state_d = WRITE;
        end
      end

      DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // buf_q holds the last written word, so mem_wd is stable between writes.
  assign mem_wd = buf_q;

  // Reset kills the write in the very cycle it is raised.
  assign mem_we = we_int & ~RST;

endmodule
